control_sequencer: RTL and testbench

Hardwired micro-operation sequencer for the 8-bit relatively-simple CPU. It consumes the timing states T0–T7 and one-hot instruction lines produced by the control-step block. It drives back the timing counter's INC/CLEAR and the op decoder's FULL_RESET. It emits every register-transfer, ALU and memory strobe for fetch and execute, with memory wait-state handshaking, run/pause/single-step control and a retired-instruction counter.

---
 rtl/control_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired micro-operation sequencer for the 8-bit relatively-simple CPU.
// Decodes T0-T7 and one-hot instruction lines into strobes, with memory wait states and run/step control.
module control_sequencer (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        T0,
  input  logic        T1,
  input  logic        T2,
  input  logic        T3,
  input  logic        T4,
  input  logic        T5,
  input  logic        T6,
  input  logic        T7,
  input  logic        INOP,
  input  logic        ILDAC,
  input  logic        ISTAC,
  input  logic        IMVAC,
  input  logic        IMOVR,
  input  logic        IJUMP,
  input  logic        IJMPZ,
  input  logic        IJPNZ,
  input  logic        IADD,
  input  logic        ISUB,
  input  logic        IINAC,
  input  logic        ICLAC,
  input  logic        IAND,
  input  logic        IOR,
  input  logic        IXOR,
  input  logic        INOT,
  input  logic        Z,
  input  logic        MEM_READY,
  input  logic        RUN,
  input  logic        STEP,
  output logic        INC,
  output logic        CLEAR,
  output logic        FULL_RESET,
  output logic        ARLOAD,
  output logic        ARINC,
  output logic        PCLOAD,
  output logic        PCINC,
  output logic        DRLOAD,
  output logic        TRLOAD,
  output logic        IRLOAD,
  output logic        RLOAD,
  output logic        ACLOAD,
  output logic        ZLOAD,
  output logic        PCBUS,
  output logic        DRBUS,
  output logic        TRBUS,
  output logic        RBUS,
  output logic        ACBUS,
  output logic        MEMBUS,
  output logic        BUSMEM,
  output logic        READ,
  output logic        WRITE,
  output logic [3:0]  ALU_OP,
  output logic        PAUSED,
  output logic [15:0] INSTR_COUNT
);

  typedef enum logic [1:0] {
    S_CLR   = 2'd0,
    S_RUN   = 2'd1,
    S_STEP1 = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  typedef struct packed {
    logic       arload;
    logic       arinc;
    logic       pcload;
    logic       pcinc;
    logic       drload;
    logic       trload;
    logic       irload;
    logic       rload;
    logic       acload;
    logic       zload;
    logic       pcbus;
    logic       drbus;
    logic       trbus;
    logic       rbus;
    logic       acbus;
    logic       membus;
    logic       busmem;
    logic       read;
    logic       write;
    logic       clear;
    logic [3:0] alu_op;
  } uop_t;

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] count_reg;
  logic        retire;
  logic        stall;
  uop_t        uop;

  logic        addr_fetch;
  logic        jump_taken;
  logic        jump_untaken;
  logic        alu_instr;
  logic        alu_rbus;
  logic [3:0]  alu_code;

  assign addr_fetch   = ILDAC | ISTAC;
  assign jump_taken   = IJUMP | (IJMPZ & Z) | (IJPNZ & ~Z);
  assign jump_untaken = (IJMPZ & ~Z) | (IJPNZ & Z);
  assign INSTR_COUNT  = count_reg;

  always_comb begin
    alu_code  = 4'd0;
    alu_rbus  = 1'b0;
    alu_instr = 1'b1;
    if (IADD) begin
      alu_code = 4'd1;
      alu_rbus = 1'b1;
    end else if (ISUB) begin
      alu_code = 4'd2;
      alu_rbus = 1'b1;
    end else if (IINAC) begin
      alu_code = 4'd3;
    end else if (ICLAC) begin
      alu_code = 4'd4;
    end else if (IAND) begin
      alu_code = 4'd5;
      alu_rbus = 1'b1;
    end else if (IOR) begin
      alu_code = 4'd6;
      alu_rbus = 1'b1;
    end else if (IXOR) begin
      alu_code = 4'd7;
      alu_rbus = 1'b1;
    end else if (INOT) begin
      alu_code = 4'd8;
    end else begin
      alu_instr = 1'b0;
    end
  end

  // Raw micro-program; any step without a defined operation terminates so the counter never stalls.
  always_comb begin
    uop = '0;
    if (T0) begin
      uop.pcbus  = 1'b1;
      uop.arload = 1'b1;
    end else if (T1) begin
      uop.read   = 1'b1;
      uop.membus = 1'b1;
      uop.drload = 1'b1;
      uop.pcinc  = 1'b1;
    end else if (T2) begin
      uop.irload = 1'b1;
      uop.pcbus  = 1'b1;
      uop.arload = 1'b1;
    end else if (T3) begin
      if (addr_fetch) begin
        uop.read   = 1'b1;
        uop.membus = 1'b1;
        uop.drload = 1'b1;
        uop.pcinc  = 1'b1;
        uop.arinc  = 1'b1;
      end else if (IMVAC) begin
        uop.acbus = 1'b1;
        uop.rload = 1'b1;
        uop.clear = 1'b1;
      end else if (IMOVR) begin
        uop.rbus   = 1'b1;
        uop.acload = 1'b1;
        uop.zload  = 1'b1;
        uop.clear  = 1'b1;
      end else if (jump_taken) begin
        uop.read   = 1'b1;
        uop.membus = 1'b1;
        uop.drload = 1'b1;
        uop.arinc  = 1'b1;
      end else if (jump_untaken) begin
        uop.pcinc = 1'b1;
      end else if (alu_instr) begin
        uop.acload = 1'b1;
        uop.zload  = 1'b1;
        uop.rbus   = alu_rbus;
        uop.alu_op = alu_code;
        uop.clear  = 1'b1;
      end else begin
        uop.clear = 1'b1;
      end
    end else if (T4) begin
      if (addr_fetch || jump_taken) begin
        uop.read   = 1'b1;
        uop.membus = 1'b1;
        uop.drload = 1'b1;
        uop.trload = 1'b1;
        uop.pcinc  = addr_fetch;
      end else if (jump_untaken) begin
        uop.pcinc = 1'b1;
        uop.clear = 1'b1;
      end else begin
        uop.clear = 1'b1;
      end
    end else if (T5) begin
      if (addr_fetch) begin
        uop.drbus  = 1'b1;
        uop.trbus  = 1'b1;
        uop.arload = 1'b1;
      end else if (jump_taken) begin
        uop.drbus  = 1'b1;
        uop.trbus  = 1'b1;
        uop.pcload = 1'b1;
        uop.clear  = 1'b1;
      end else begin
        uop.clear = 1'b1;
      end
    end else if (T6) begin
      if (ILDAC) begin
        uop.read   = 1'b1;
        uop.membus = 1'b1;
        uop.drload = 1'b1;
      end else if (ISTAC) begin
        uop.acbus  = 1'b1;
        uop.drload = 1'b1;
      end else begin
        uop.clear = 1'b1;
      end
    end else if (T7) begin
      if (ILDAC) begin
        uop.drbus  = 1'b1;
        uop.acload = 1'b1;
        uop.zload  = 1'b1;
        uop.clear  = 1'b1;
      end else if (ISTAC) begin
        uop.write  = 1'b1;
        uop.drbus  = 1'b1;
        uop.busmem = 1'b1;
        uop.clear  = 1'b1;
      end else begin
        uop.clear = 1'b1;
      end
    end else begin
      uop.clear = 1'b1;
    end
  end

  assign stall = (uop.read | uop.write) & ~MEM_READY;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_reg <= S_CLR;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        count_reg <= count_reg + 16'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    INC        = 1'b0;
    CLEAR      = 1'b0;
    FULL_RESET = 1'b0;
    ARLOAD     = 1'b0;
    ARINC      = 1'b0;
    PCLOAD     = 1'b0;
    PCINC      = 1'b0;
    DRLOAD     = 1'b0;
    TRLOAD     = 1'b0;
    IRLOAD     = 1'b0;
    RLOAD      = 1'b0;
    ACLOAD     = 1'b0;
    ZLOAD      = 1'b0;
    PCBUS      = 1'b0;
    DRBUS      = 1'b0;
    TRBUS      = 1'b0;
    RBUS       = 1'b0;
    ACBUS      = 1'b0;
    MEMBUS     = 1'b0;
    BUSMEM     = 1'b0;
    READ       = 1'b0;
    WRITE      = 1'b0;
    ALU_OP     = 4'd0;
    PAUSED     = 1'b0;
    case (state_reg)
      S_CLR: begin
        CLEAR      = 1'b1;
        FULL_RESET = 1'b1;
        state_next = RUN ? S_RUN : S_PAUSE;
      end
      S_PAUSE: begin
        PAUSED = 1'b1;
        if (RUN) begin
          state_next = S_RUN;
        end else if (STEP) begin
          state_next = S_STEP1;
        end
      end
      S_RUN, S_STEP1: begin
        // Bus and address drivers hold through a wait state; state-changing strobes wait for MEM_READY.
        READ   = uop.read;
        WRITE  = uop.write;
        PCBUS  = uop.pcbus;
        DRBUS  = uop.drbus;
        TRBUS  = uop.trbus;
        RBUS   = uop.rbus;
        ACBUS  = uop.acbus;
        MEMBUS = uop.membus;
        BUSMEM = uop.busmem;
        ALU_OP = uop.alu_op;
        if (!stall) begin
          ARLOAD = uop.arload;
          ARINC  = uop.arinc;
          PCLOAD = uop.pcload;
          PCINC  = uop.pcinc;
          DRLOAD = uop.drload;
          TRLOAD = uop.trload;
          IRLOAD = uop.irload;
          RLOAD  = uop.rload;
          ACLOAD = uop.acload;
          ZLOAD  = uop.zload;
          INC    = ~uop.clear;
          CLEAR  = uop.clear;
          if (uop.clear) begin
            retire     = 1'b1;
            state_next = (state_reg == S_RUN && RUN) ? S_RUN : S_PAUSE;
          end
        end
      end
      default: state_next = S_CLR;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a timing-counter model feeds T0-T7 back from INC/CLEAR,
// each expected instruction summary is queued and a monitor checks it when CLEAR or PAUSED appears.
module tb_control_sequencer;

  localparam int I_NOP = 0, I_LDAC = 1, I_STAC = 2, I_MVAC = 3, I_MOVR = 4, I_JUMP = 5,
                 I_JMPZ = 6, I_JPNZ = 7, I_ADD = 8, I_SUB = 9, I_INAC = 10, I_CLAC = 11,
                 I_AND = 12, I_OR = 13, I_XOR = 14, I_NOT = 15, I_NONE = -1;
  localparam int K_CLEAR = 0, K_PAUSE = 1;

  typedef struct {
    int    kind;
    string name;
    int    cycles;
    int    reads;
    int    writes;
    int    drloads;
    int    pcincs;
    int    pcloads;
    int    acloads;
    int    incs;
    int    alu;
    int    count;
    int    fr;
  } exp_t;

  logic        clk;
  logic        RESET_N, Z, MEM_READY, RUN, STEP;
  logic [7:0]  tvec;
  logic [15:0] ilines;
  logic        INC, CLEAR, FULL_RESET, ARLOAD, ARINC, PCLOAD, PCINC, DRLOAD, TRLOAD, IRLOAD;
  logic        RLOAD, ACLOAD, ZLOAD, PCBUS, DRBUS, TRBUS, RBUS, ACBUS, MEMBUS, BUSMEM;
  logic        READ, WRITE, PAUSED;
  logic [3:0]  ALU_OP;
  logic [15:0] INSTR_COUNT;
  logic [25:0] strobes;

  logic [2:0]  t_reg;
  int          wait_used;
  int          wait_t;
  int          wait_total;
  int          cur_instr;
  logic        force_t3;
  logic        mon_en;

  exp_t        sb[$];
  exp_t        cur_e;
  int          pushed, seen;
  int          tests, fails;
  int          timeouts_req, timeouts_seen;
  int          acc_cycles, acc_reads, acc_writes, acc_drloads, acc_pcincs, acc_pcloads, acc_acloads, acc_incs;
  logic        paused_prev;

  control_sequencer dut (
    .CLK(clk), .RESET_N(RESET_N),
    .T0(tvec[0]), .T1(tvec[1]), .T2(tvec[2]), .T3(tvec[3]),
    .T4(tvec[4]), .T5(tvec[5]), .T6(tvec[6]), .T7(tvec[7]),
    .INOP(ilines[0]), .ILDAC(ilines[1]), .ISTAC(ilines[2]), .IMVAC(ilines[3]),
    .IMOVR(ilines[4]), .IJUMP(ilines[5]), .IJMPZ(ilines[6]), .IJPNZ(ilines[7]),
    .IADD(ilines[8]), .ISUB(ilines[9]), .IINAC(ilines[10]), .ICLAC(ilines[11]),
    .IAND(ilines[12]), .IOR(ilines[13]), .IXOR(ilines[14]), .INOT(ilines[15]),
    .Z(Z), .MEM_READY(MEM_READY), .RUN(RUN), .STEP(STEP),
    .INC(INC), .CLEAR(CLEAR), .FULL_RESET(FULL_RESET),
    .ARLOAD(ARLOAD), .ARINC(ARINC), .PCLOAD(PCLOAD), .PCINC(PCINC), .DRLOAD(DRLOAD),
    .TRLOAD(TRLOAD), .IRLOAD(IRLOAD), .RLOAD(RLOAD), .ACLOAD(ACLOAD), .ZLOAD(ZLOAD),
    .PCBUS(PCBUS), .DRBUS(DRBUS), .TRBUS(TRBUS), .RBUS(RBUS), .ACBUS(ACBUS),
    .MEMBUS(MEMBUS), .BUSMEM(BUSMEM), .READ(READ), .WRITE(WRITE),
    .ALU_OP(ALU_OP), .PAUSED(PAUSED), .INSTR_COUNT(INSTR_COUNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign strobes = {INC, CLEAR, FULL_RESET, ARLOAD, ARINC, PCLOAD, PCINC, DRLOAD, TRLOAD, IRLOAD,
                    RLOAD, ACLOAD, ZLOAD, PCBUS, DRBUS, TRBUS, RBUS, ACBUS, MEMBUS, BUSMEM,
                    READ, WRITE, ALU_OP};
  assign MEM_READY = !((int'(t_reg) == wait_t) && (wait_used < wait_total));

  // Timing-counter model (the control-step block)
  always @(posedge clk) begin
    if (!RESET_N || CLEAR) begin
      t_reg     <= 3'd0;
      wait_used <= 0;
    end else begin
      if (INC) t_reg <= t_reg + 3'd1;
      if (!MEM_READY) wait_used <= wait_used + 1;
    end
  end

  always_comb begin
    tvec   = force_t3 ? 8'h08 : (8'h01 << t_reg);
    ilines = '0;
    if ((force_t3 || t_reg >= 3'd3) && cur_instr >= 0 && cur_instr < 16) ilines[cur_instr] = 1'b1;
  end

  task automatic chk(input string nm, input string fld, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("[TB] FAIL %s %s: got %0d, expected %0d", nm, fld, act, exp_v);
    end
  endtask

  task automatic pop_check(input int kind);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL unexpected event kind %0d: got event, expected none", kind);
    end else begin
      cur_e = sb.pop_front();
      seen++;
      chk(cur_e.name, "kind", kind, cur_e.kind);
      chk(cur_e.name, "count", int'(INSTR_COUNT), cur_e.count);
      if (kind == K_PAUSE) begin
        chk(cur_e.name, "strobes", int'(strobes), 0);
        $display("[TB] %s: paused, count=%0d", cur_e.name, INSTR_COUNT);
      end else begin
        chk(cur_e.name, "cycles", acc_cycles, cur_e.cycles);
        chk(cur_e.name, "reads", acc_reads, cur_e.reads);
        chk(cur_e.name, "writes", acc_writes, cur_e.writes);
        chk(cur_e.name, "drloads", acc_drloads, cur_e.drloads);
        chk(cur_e.name, "pcincs", acc_pcincs, cur_e.pcincs);
        chk(cur_e.name, "pcloads", acc_pcloads, cur_e.pcloads);
        chk(cur_e.name, "acloads", acc_acloads, cur_e.acloads);
        chk(cur_e.name, "incs", acc_incs, cur_e.incs);
        chk(cur_e.name, "alu_op", int'(ALU_OP), cur_e.alu);
        chk(cur_e.name, "full_reset", int'(FULL_RESET), cur_e.fr);
        $display("[TB] %s: cycles=%0d reads=%0d writes=%0d count=%0d", cur_e.name, acc_cycles,
                 acc_reads, acc_writes, INSTR_COUNT);
      end
    end
  endtask

  // Monitor: accumulate per-instruction activity, compare at each CLEAR or PAUSED rise
  always @(negedge clk) begin
    if (timeouts_seen != timeouts_req) begin
      tests++;
      fails++;
      $display("[TB] FAIL timeout: got %0d of %0d expected events", seen, pushed);
      timeouts_seen = timeouts_req;
    end
    if (!RESET_N || !mon_en || PAUSED) begin
      if (RESET_N && mon_en && PAUSED && !paused_prev) pop_check(K_PAUSE);
      paused_prev = RESET_N && mon_en && PAUSED;
      acc_cycles = 0; acc_reads = 0; acc_writes = 0; acc_drloads = 0;
      acc_pcincs = 0; acc_pcloads = 0; acc_acloads = 0; acc_incs = 0;
    end else begin
      paused_prev = 1'b0;
      acc_cycles++;
      acc_reads   += int'(READ);
      acc_writes  += int'(WRITE);
      acc_drloads += int'(DRLOAD);
      acc_pcincs  += int'(PCINC);
      acc_pcloads += int'(PCLOAD);
      acc_acloads += int'(ACLOAD);
      acc_incs    += int'(INC);
      if (CLEAR) begin
        pop_check(K_CLEAR);
        acc_cycles = 0; acc_reads = 0; acc_writes = 0; acc_drloads = 0;
        acc_pcincs = 0; acc_pcloads = 0; acc_acloads = 0; acc_incs = 0;
      end
    end
  end

  function automatic exp_t mk(input string nm, input int cyc, input int rd, input int wr,
                              input int drl, input int pci, input int pcl, input int acl,
                              input int inc, input int alu, input int cnt, input int fr);
    exp_t e;
    e.kind = K_CLEAR; e.name = nm; e.cycles = cyc; e.reads = rd; e.writes = wr;
    e.drloads = drl; e.pcincs = pci; e.pcloads = pcl; e.acloads = acl; e.incs = inc;
    e.alu = alu; e.count = cnt; e.fr = fr;
    return e;
  endfunction

  function automatic exp_t mk_pause(input string nm, input int cnt);
    exp_t e;
    e = mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, cnt, 0);
    e.kind = K_PAUSE;
    return e;
  endfunction

  task automatic push_exp(input exp_t e);
    sb.push_back(e);
    pushed++;
  endtask

  task automatic wait_events(input int budget);
    int n = 0;
    while (seen < pushed && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (seen < pushed) timeouts_req++;
  endtask

  task automatic wait_t_state(input int tv, input int budget);
    int n = 0;
    while (int'(t_reg) != tv && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (int'(t_reg) != tv) timeouts_req++;
  endtask

  task automatic do_instr(input int instr, input logic zv, input exp_t e);
    cur_instr = instr;
    Z = zv;
    push_exp(e);
    wait_events(40);
  endtask

  initial begin
    RESET_N = 1'b0; RUN = 1'b1; STEP = 1'b0; Z = 1'b0;
    wait_t = 7; wait_total = 0; cur_instr = I_ADD; force_t3 = 1'b0; mon_en = 1'b1;
    pushed = 0; seen = 0; tests = 0; fails = 0; timeouts_req = 0; timeouts_seen = 0;
    paused_prev = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push_exp(mk("reset_clr", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    RESET_N = 1'b1;
    wait_events(10);

    //                        cyc rd wr drl pci pcl acl inc alu cnt fr
    do_instr(I_ADD, 1'b0, mk("add", 4, 1, 0, 1, 1, 0, 1, 3, 1, 0, 0));
    wait_t = 6; wait_total = 2;
    do_instr(I_LDAC, 1'b0, mk("ldac_wait2", 10, 6, 0, 4, 3, 0, 1, 7, 0, 1, 0));
    wait_total = 0;
    do_instr(I_JMPZ, 1'b0, mk("jmpz_untaken", 5, 1, 0, 1, 3, 0, 0, 4, 0, 2, 0));
    do_instr(I_JMPZ, 1'b1, mk("jmpz_taken", 6, 3, 0, 3, 1, 1, 0, 5, 0, 3, 0));
    do_instr(I_JPNZ, 1'b1, mk("jpnz_untaken", 5, 1, 0, 1, 3, 0, 0, 4, 0, 4, 0));
    do_instr(I_JUMP, 1'b0, mk("jump", 6, 3, 0, 3, 1, 1, 0, 5, 0, 5, 0));
    do_instr(I_MOVR, 1'b0, mk("movr", 4, 1, 0, 1, 1, 0, 1, 3, 0, 6, 0));
    do_instr(I_MVAC, 1'b0, mk("mvac", 4, 1, 0, 1, 1, 0, 0, 3, 0, 7, 0));
    do_instr(I_XOR, 1'b0, mk("xor", 4, 1, 0, 1, 1, 0, 1, 3, 7, 8, 0));
    do_instr(I_NOT, 1'b0, mk("not", 4, 1, 0, 1, 1, 0, 1, 3, 8, 9, 0));
    do_instr(I_CLAC, 1'b0, mk("clac", 4, 1, 0, 1, 1, 0, 1, 3, 4, 10, 0));
    do_instr(I_NONE, 1'b0, mk("no_line", 4, 1, 0, 1, 1, 0, 0, 3, 0, 11, 0));

    // RUN drops at T4 of STAC: instruction completes, then pause
    cur_instr = I_STAC;
    push_exp(mk("stac_run_drop", 8, 3, 1, 4, 3, 0, 0, 7, 0, 12, 0));
    push_exp(mk_pause("pause_after_stac", 13));
    wait_t_state(4, 20);
    RUN = 1'b0;
    wait_events(40);

    cur_instr = I_NOP;
    push_exp(mk("step_nop", 4, 1, 0, 1, 1, 0, 0, 3, 0, 13, 0));
    push_exp(mk_pause("pause_after_step", 14));
    STEP = 1'b1;
    @(posedge clk);
    #1;
    STEP = 1'b0;
    wait_events(40);

    // Counter wrap: hold T3 with INOP so every cycle retires one instruction
    mon_en = 1'b0;
    force_t3 = 1'b1;
    RUN = 1'b1;
    @(posedge clk);
    repeat (65536 - 14) @(posedge clk);
    #1;
    force_t3 = 1'b0;
    mon_en = 1'b1;
    do_instr(I_NOP, 1'b0, mk("nop_after_wrap", 4, 1, 0, 1, 1, 0, 0, 3, 0, 0, 0));
    do_instr(I_SUB, 1'b0, mk("sub", 4, 1, 0, 1, 1, 0, 1, 3, 2, 1, 0));

    // Reset in the middle of an LDAC wait state
    cur_instr = I_LDAC;
    wait_t = 6; wait_total = 50;
    wait_t_state(6, 20);
    repeat (2) @(posedge clk);
    #1;
    push_exp(mk("reset_in_wait", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    RESET_N = 1'b0;
    @(posedge clk);
    #1;
    RESET_N = 1'b1;
    wait_total = 0;
    wait_events(10);
    do_instr(I_AND, 1'b0, mk("and_after_reset", 4, 1, 0, 1, 1, 0, 1, 3, 5, 0, 0));

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
